apb_timer_regs: RTL
===================

Name: apb_timer_regs

Overview:
- Zero-wait-state APB slave that sits directly downstream of the ral_if-style bus and is the register-model target for the RAL environment.
- Decodes the 4-bit PADDR into four 32-bit word registers: CTRL, CMP, STATUS and COUNT.
- Runs a free-running up-counter with a compare match that raises a sticky interrupt.
- Tracks APB phases with an explicit FSM, flags protocol violations, and returns registered read data during the access phase.

Parameters:
- CNT_RST, 32'h0000_0000, reset value of COUNT.
- CMP_RST, 32'hFFFF_FFFF, reset value of CMP.

Ports:
- PCLK  input  1  bus and block clock; all logic on the rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  4  byte address; word-aligned, so PADDR[1:0] is ignored.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, valid in the access phase.
- irq  output  1  equals STATUS[0].

Behaviour:
- Reset: applied at the PCLK edge while PRESET=1; it overrides any transfer in flight, and the FSM returns to IDLE.
  - PRDATA=0, irq=0, CTRL=0, CMP=CMP_RST, COUNT=CNT_RST, STATUS=0.
- Register map, decoded on PADDR[3:2]:
  - 0x0 CTRL, RW. Bit0 = cnt_en, bit1 = auto_clr (COUNT reloads 0 on match). Bits [31:2] read 0; writes to them are ignored.
  - 0x4 CMP, RW, full 32 bits.
  - 0x8 STATUS:
    - bit0 match_irq: sticky; W1C.
    - bit1 prot_err: sticky; W1C.
    - bits[15:8] wr_cnt: read-only; counts committed writes; 8-bit wrap 0xFF->0x00.
    - Other bits read 0.
  - 0xC COUNT, RW. A write loads COUNT.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: PSEL&!PENABLE -> SETUP. PSEL&PENABLE -> stays IDLE, sets prot_err, no transfer. Otherwise stays IDLE.
  - SETUP: the setup PADDR/PWRITE are latched on entering SETUP.
    - PSEL&PENABLE with PADDR and PWRITE unchanged from the latched values -> ACCESS.
    - Any other input -> IDLE and sets prot_err: PSEL low, PENABLE low, or PADDR/PWRITE changed.
  - ACCESS: lasts one cycle, since there is no PREADY.
    - PSEL&!PENABLE -> SETUP (back-to-back transfer).
    - Otherwise -> IDLE.
- Write commit:
  - Occurs at the edge that takes SETUP->ACCESS with PWRITE=1; the register updates that edge.
  - wr_cnt increments on the same edge.
  - Writing STATUS counts as a committed write.
- Read:
  - PRDATA is loaded from the addressed register at the edge entering SETUP, so it is valid throughout the access cycle.
  - PRDATA holds its value until the next read setup; writes never change PRDATA.
- Counter:
  - When cnt_en=1, COUNT increments by 1 each cycle, wrapping 0xFFFF_FFFF->0x0000_0000.
  - Match: COUNT==CMP while cnt_en=1. The edge after the match sets match_irq. If auto_clr=1, COUNT loads 0 instead of incrementing.
  - When cnt_en=0, COUNT holds and no new matches occur.
- Simultaneous events:
  - SW write to COUNT in the same cycle as an increment or auto_clr: the SW write wins.
  - W1C of match_irq in the same cycle as a new match: set wins, irq stays 1. Same rule for prot_err against a new violation.
- irq is registered and equals STATUS[0] in every cycle.

Optional Feature:
- Macro APB_SLVERR_EN.
- When defined:
  - Adds output PSLVERR, 1 bit, reset 0.
  - PSLVERR is asserted only in the ACCESS cycle when either condition holds:
    - the write targets STATUS with PWDATA[15:8] nonzero (an attempted write to wr_cnt), or
    - PADDR[1:0]!=0.
  - For an unaligned access, the write is suppressed and read data is 0.
  - PSLVERR is 0 in all other cycles.
- When undefined:
  - No PSLVERR port.
  - Unaligned accesses decode on PADDR[3:2]; nonzero wr_cnt write bits are silently ignored.

Test Plan:
- Reset with PRESET=1 for 2 cycles, then read all four addresses -> CTRL=0, CMP=0xFFFF_FFFF, STATUS=0, COUNT=0.
- Write CMP=5, write CTRL=1, then poll -> match_irq and irq rise the cycle after COUNT==5. Write STATUS=1 -> irq=0. STATUS[15:8] reads 2 after the first two writes.
- Write CMP=3 and CTRL=3 (auto_clr) -> COUNT sequence 0,1,2,3,0,1... and irq set on the first match.
- Write COUNT=0xFFFF_FFFE and enable -> COUNT wraps through 0xFFFF_FFFF to 0. Write COUNT=0x10 while enabled -> next read returns 0x10 plus the elapsed cycles.
- Protocol errors:
  - PENABLE raised without a setup phase -> STATUS[1]=1 and no register change.
  - PADDR changed between setup and access -> STATUS[1]=1 and write suppressed.
- Assert PRESET mid-access during a write of CMP=7 -> CMP stays 0xFFFF_FFFF and FSM returns to IDLE. With APB_SLVERR_EN defined, a write to PADDR=0x5 -> PSLVERR=1 in the access cycle and no register change.

Source files
------------

// File: rtl/apb_timer_regs.sv
// rtl/apb_timer_regs.sv - APB timer register block: CTRL/CMP/STATUS/COUNT, compare irq, phase FSM.
// Optional APB_SLVERR_EN adds PSLVERR for unaligned accesses and attempted wr_cnt writes.
module apb_timer_regs #(
    parameter logic [31:0] CNT_RST = 32'h0000_0000,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
`ifdef APB_SLVERR_EN
    output logic        PSLVERR,
`endif
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        prot_q, prot_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0] prdata_q, prdata_d;

    logic        enter_setup, access_go, prot_set, commit, match;
    logic        wr_ctrl, wr_cmp, wr_status, wr_count;
    logic [31:0] rd_mux;

    always_comb begin
        state_d     = state_q;
        enter_setup = 1'b0;
        access_go   = 1'b0;
        prot_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE)     enter_setup = 1'b1;
                else if (PSEL && PENABLE) prot_set = 1'b1;
            end
            SETUP: begin
                if (PSEL && PENABLE && (PADDR == addr_q) && (PWRITE == write_q)) begin
                    state_d   = ACCESS;
                    access_go = 1'b1;
                end else begin
                    state_d  = IDLE;
                    prot_set = 1'b1;
                end
            end
            ACCESS: begin
                if (PSEL && !PENABLE) enter_setup = 1'b1;
                else                  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (enter_setup) state_d = SETUP;
    end

    always_comb begin
        rd_mux = 32'h0;
        case (PADDR[3:2])
            2'd0: rd_mux = {30'h0, ctrl_q};
            2'd1: rd_mux = cmp_q;
            2'd2: rd_mux = {16'h0, wr_cnt_q, 6'h0, prot_q, irq_q};
            2'd3: rd_mux = count_q;
            default: rd_mux = 32'h0;
        endcase
`ifdef APB_SLVERR_EN
        if (PADDR[1:0] != 2'b00) rd_mux = 32'h0;
`endif
    end

`ifdef APB_SLVERR_EN
    logic pslverr_q, pslverr_d;
    assign commit    = access_go && write_q && (addr_q[1:0] == 2'b00);
    assign pslverr_d = access_go && ((addr_q[1:0] != 2'b00) ||
                       (write_q && (addr_q[3:2] == 2'd2) && (PWDATA[15:8] != 8'h00)));
    assign PSLVERR   = pslverr_q;
`else
    assign commit = access_go && write_q;
`endif

    assign wr_ctrl   = commit && (addr_q[3:2] == 2'd0);
    assign wr_cmp    = commit && (addr_q[3:2] == 2'd1);
    assign wr_status = commit && (addr_q[3:2] == 2'd2);
    assign wr_count  = commit && (addr_q[3:2] == 2'd3);
    assign match     = ctrl_q[0] && (count_q == cmp_q);

    always_comb begin
        addr_d   = enter_setup ? PADDR : addr_q;
        write_d  = enter_setup ? PWRITE : write_q;
        prdata_d = (enter_setup && !PWRITE) ? rd_mux : prdata_q;
        ctrl_d   = wr_ctrl ? PWDATA[1:0] : ctrl_q;
        cmp_d    = wr_cmp ? PWDATA : cmp_q;
        wr_cnt_d = commit ? wr_cnt_q + 8'd1 : wr_cnt_q;
        // New events take priority over a same-cycle W1C.
        irq_d    = match || (irq_q && !(wr_status && PWDATA[0]));
        prot_d   = prot_set || (prot_q && !(wr_status && PWDATA[1]));
        count_d  = count_q;
        if (wr_count)                   count_d = PWDATA;
        else if (match && ctrl_q[1])    count_d = 32'h0;
        else if (ctrl_q[0])             count_d = count_q + 32'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            addr_q    <= 4'h0;
            write_q   <= 1'b0;
            ctrl_q    <= 2'b00;
            cmp_q     <= CMP_RST;
            count_q   <= CNT_RST;
            irq_q     <= 1'b0;
            prot_q    <= 1'b0;
            wr_cnt_q  <= 8'h00;
            prdata_q  <= 32'h0;
`ifdef APB_SLVERR_EN
            pslverr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            ctrl_q    <= ctrl_d;
            cmp_q     <= cmp_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
            prot_q    <= prot_d;
            wr_cnt_q  <= wr_cnt_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLVERR_EN
            pslverr_q <= pslverr_d;
`endif
        end
    end

    assign PRDATA = prdata_q;
    assign irq    = irq_q;

endmodule
